// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/HALTED control FSM with branch redirect, stall and fetch-wait handling.
module instr_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                halt_in,
    output logic [31:0]         ifid_instr,
    output logic [PC_WIDTH-1:0] ifid_pc_plus4,
    output logic                ifid_valid,
    output logic [5:0]          opcode,
    output logic                halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [31:0]         instr_next;
    logic [PC_WIDTH-1:0] pc4_next;
    logic                valid_next;

    // Natural wrap modulo 2^PC_WIDTH is intended; no overflow is reported.
    assign pc_inc = pc + PC_WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            ifid_instr    <= 32'h0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            ifid_instr    <= instr_next;
            ifid_pc_plus4 <= pc4_next;
            ifid_valid    <= valid_next;
        end
    end

    // Branch beats halt beats stall beats fetch-wait; only reset leaves HALTED.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = ifid_instr;
        pc4_next   = ifid_pc_plus4;
        valid_next = ifid_valid;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    pc_next    = {branch_target[PC_WIDTH-1:2], 2'b00};
                    valid_next = 1'b0;
                    instr_next = 32'h0;
                end else if (halt_in && ifid_valid) begin
                    state_next = HALTED;
                    valid_next = 1'b0;
                end else if (stall) begin
                    valid_next = ifid_valid;
                end else if (!imem_ready) begin
                    valid_next = 1'b0;
                end else begin
                    instr_next = imem_rdata;
                    pc4_next   = pc_inc;
                    valid_next = 1'b1;
                    pc_next    = pc_inc;
                end
            end
            HALTED: begin
                valid_next = 1'b0;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Request is gated by rst_n so it drops immediately when reset asserts.
    assign imem_req  = rst_n && (state == RUN);
    assign imem_addr = pc;
    assign opcode    = ifid_instr[31:26];
    assign halted    = (state == HALTED);

endmodule
